// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: opcodes, immediate formats,
// FSM states, PC/writeback mux selects and the instruction class produced by the decoder.
package control_fsm_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   typedef enum logic [2:0] {
      I_IMM = 3'd0,
      S_IMM = 3'd1,
      B_IMM = 3'd2,
      J_IMM = 3'd3,
      U_IMM = 3'd4
   } imm_sel_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_IMM   = 2'd1,
      PC_ALU   = 2'd2
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2
   } wb_sel_e;

   typedef enum logic [3:0] {
      CL_OP_IMM  = 4'd0,
      CL_OP      = 4'd1,
      CL_LOAD    = 4'd2,
      CL_STORE   = 4'd3,
      CL_BRANCH  = 4'd4,
      CL_JAL     = 4'd5,
      CL_JALR    = 4'd6,
      CL_LUI     = 4'd7,
      CL_AUIPC   = 4'd8,
      CL_ILLEGAL = 4'd9
   } op_class_e;

endpackage

// File: rtl/control_fsm_if.sv
// Instruction/data memory handshake bundle between the control FSM (master)
// and the memory system (slave).
interface control_fsm_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (output imem_req, output dmem_req, output dmem_we,
                   input  imem_ack, input  dmem_ack);
   modport slave  (input  imem_req, input  dmem_req, input  dmem_we,
                   output imem_ack, output dmem_ack);
endinterface

// File: rtl/control_fsm_opcode_decode.sv
// Combinational opcode classifier: maps inst[6:0] to an instruction class and
// immediate format. Anything with inst[1:0] != 2'b11 or an unlisted opcode is illegal.
module opcode_decode
   import control_fsm_pkg::*;
(
   input  logic [6:0] i_opcode,
   output op_class_e  o_class,
   output imm_sel_e   o_imm_sel
);

   always_comb begin
      o_class   = CL_ILLEGAL;
      o_imm_sel = I_IMM;
      if (i_opcode[1:0] == 2'b11) begin
         case (i_opcode)
            OPC_OP_IMM: begin o_class = CL_OP_IMM; o_imm_sel = I_IMM; end
            OPC_OP:     begin o_class = CL_OP;     o_imm_sel = I_IMM; end
            OPC_LOAD:   begin o_class = CL_LOAD;   o_imm_sel = I_IMM; end
            OPC_STORE:  begin o_class = CL_STORE;  o_imm_sel = S_IMM; end
            OPC_BRANCH: begin o_class = CL_BRANCH; o_imm_sel = B_IMM; end
            OPC_JAL:    begin o_class = CL_JAL;    o_imm_sel = J_IMM; end
            OPC_JALR:   begin o_class = CL_JALR;   o_imm_sel = I_IMM; end
            OPC_LUI:    begin o_class = CL_LUI;    o_imm_sel = U_IMM; end
            OPC_AUIPC:  begin o_class = CL_AUIPC;  o_imm_sel = U_IMM; end
            default:    begin o_class = CL_ILLEGAL; o_imm_sel = I_IMM; end
         endcase
      end
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with a memory-ack watchdog.
// Define ILLEGAL_TRAP_EN to halt on unknown opcodes and expose a sticky illegal_op flag.
module control_fsm
   import control_fsm_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
)
(
   input  logic                clk,
   input  logic                rst,
   control_fsm_if.master       mem,
   input  logic [31:0]         inst,
   input  logic                br_taken,
   output logic                ir_we,
   output logic                pc_we,
   output logic [1:0]          pc_sel,
   output logic [2:0]          ImmSel,
   output logic                alu_src_b,
   output logic                reg_we,
   output logic [1:0]          wb_sel,
   output logic [2:0]          state,
   output logic                bus_err
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic                illegal_op
`endif
);

   localparam int            CW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYC - 1);

   state_e        r_state;
   state_e        w_next;
   logic [CW-1:0] r_wait_cnt;
   imm_sel_e      r_imm_sel;
   op_class_e     r_class;
   logic          r_bus_err;
   op_class_e     w_dec_class;
   imm_sel_e      w_dec_imm;
   logic          w_timeout;
   logic          w_set_bus_err;
   logic          w_set_illegal;
   logic          w_imem_req;
   logic          w_dmem_req;
   logic          w_dmem_we;
   logic          w_unused_inst;

   assign w_unused_inst = &{1'b0, inst[31:7]};

   opcode_decode u_decode (
      .i_opcode  (inst[6:0]),
      .o_class   (w_dec_class),
      .o_imm_sel (w_dec_imm)
   );

   assign w_timeout = (r_wait_cnt == LAST_WAIT);

   // Class and immediate format are captured in DECODE so they stay valid to the end of the instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_FETCH;
         r_wait_cnt <= '0;
         r_bus_err  <= 1'b0;
         r_imm_sel  <= I_IMM;
         r_class    <= CL_OP_IMM;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_wait_cnt <= '0;
         else if (r_state == ST_FETCH || r_state == ST_MEM)
            r_wait_cnt <= r_wait_cnt + 1'b1;
         if (r_state == ST_DECODE) begin
            r_imm_sel <= w_dec_imm;
            r_class   <= w_dec_class;
         end
         if (w_set_bus_err)
            r_bus_err <= 1'b1;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic r_illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_illegal <= 1'b0;
      else if (w_set_illegal)
         r_illegal <= 1'b1;
   end

   assign illegal_op = r_illegal;
`endif

   always_comb begin
      w_next        = r_state;
      w_imem_req    = 1'b0;
      w_dmem_req    = 1'b0;
      w_dmem_we     = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = PC_PLUS4;
      alu_src_b     = 1'b0;
      reg_we        = 1'b0;
      wb_sel        = WB_ALU;
      ImmSel        = r_imm_sel;
      w_set_bus_err = 1'b0;
      w_set_illegal = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_imem_req = 1'b1;
            if (mem.imem_ack) begin
               ir_we  = 1'b1;
               w_next = ST_DECODE;
            end else if (w_timeout) begin
               w_set_bus_err = 1'b1;
               w_next        = ST_HALT;
            end
         end
         ST_DECODE: begin
            ImmSel = w_dec_imm;
            w_next = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
            if (w_dec_class == CL_ILLEGAL) begin
               w_set_illegal = 1'b1;
               w_next        = ST_HALT;
            end
`endif
         end
         ST_EXEC: begin
            alu_src_b = !(r_class inside {CL_OP, CL_BRANCH});
            case (r_class)
               CL_LOAD, CL_STORE: w_next = ST_MEM;
               CL_BRANCH: begin
                  pc_we  = 1'b1;
                  pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                  w_next = ST_FETCH;
               end
               CL_ILLEGAL: begin
                  pc_we  = 1'b1;
                  pc_sel = PC_PLUS4;
                  w_next = ST_FETCH;
               end
               default: w_next = ST_WB;
            endcase
         end
         ST_MEM: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = (r_class == CL_STORE);
            if (mem.dmem_ack) begin
               if (r_class == CL_STORE) begin
                  pc_we  = 1'b1;
                  pc_sel = PC_PLUS4;
                  w_next = ST_FETCH;
               end else begin
                  w_next = ST_WB;
               end
            end else if (w_timeout) begin
               w_set_bus_err = 1'b1;
               w_next        = ST_HALT;
            end
         end
         ST_WB: begin
            reg_we = 1'b1;
            pc_we  = 1'b1;
            case (r_class)
               CL_LOAD: wb_sel = WB_LOAD;
               CL_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_IMM; end
               CL_JALR: begin wb_sel = WB_PC4; pc_sel = PC_ALU; end
               default: wb_sel = WB_ALU;
            endcase
            w_next = ST_FETCH;
         end
         ST_HALT: w_next = ST_HALT;
         default: w_next = ST_FETCH;
      endcase
      // Reset kills every strobe at once, even while the state register is already FETCH.
      if (rst) begin
         w_imem_req = 1'b0;
         w_dmem_req = 1'b0;
         w_dmem_we  = 1'b0;
         ir_we      = 1'b0;
         pc_we      = 1'b0;
         reg_we     = 1'b0;
      end
   end

   assign mem.imem_req = w_imem_req;
   assign mem.dmem_req = w_dmem_req;
   assign mem.dmem_we  = w_dmem_we;
   assign state        = r_state;
   assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized self-checking bench for control_fsm: each instruction is expanded into an
// expected per-cycle script from its class and ack delays, then replayed against the DUT.
module tb_control_fsm;
   import control_fsm_pkg::*;

   localparam int TIMEOUT = 16;

   typedef struct {
      logic [31:0] ins;
      logic [2:0]  st;
      logic        imemReq, irWe, dmemReq, dmemWe, pcWe, regWe;
      logic [1:0]  pcSel, wbSel;
      logic [2:0]  immSel;
      logic        chkImm, chkAlt, altB;
      logic        busErr, illOp;
      logic        imemAck, dmemAck, brIn;
   } cycle_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inst  = 32'h0;
   logic        brTaken = 1'b0;
   logic        irWe, pcWe, aluSrcB, regWe, busErr;
   logic [1:0]  pcSel, wbSel;
   logic [2:0]  immSel, stateOut;
`ifdef ILLEGAL_TRAP_EN
   logic        illegalOp;
`endif

   cycle_t plan[$];
   int     checks = 0;
   int     errors = 0;

   control_fsm_if memIf ();

   control_fsm #(.TIMEOUT_CYC(TIMEOUT)) dut (
      .clk       (clock),
      .rst       (reset),
      .mem       (memIf),
      .inst      (inst),
      .br_taken  (brTaken),
      .ir_we     (irWe),
      .pc_we     (pcWe),
      .pc_sel    (pcSel),
      .ImmSel    (immSel),
      .alu_src_b (aluSrcB),
      .reg_we    (regWe),
      .wb_sel    (wbSel),
      .state     (stateOut),
      .bus_err   (busErr)
`ifdef ILLEGAL_TRAP_EN
      ,
      .illegal_op(illegalOp)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
      end
   endtask

   // Instruction class codes: 0 OP_IMM,1 OP,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI,8 AUIPC,9 unknown
   function automatic int classOf(input logic [6:0] opc);
      case (opc)
         7'h13: return 0;
         7'h33: return 1;
         7'h03: return 2;
         7'h23: return 3;
         7'h63: return 4;
         7'h6F: return 5;
         7'h67: return 6;
         7'h37: return 7;
         7'h17: return 8;
         default: return 9;
      endcase
   endfunction

   function automatic logic [2:0] immOf(input int cls);
      case (cls)
         3:       return 3'd1;
         4:       return 3'd2;
         5:       return 3'd3;
         7, 8:    return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   function automatic cycle_t idleCycle(input logic [31:0] ins, input logic [2:0] st);
      cycle_t c;
      c = '{default: '0};
      c.ins     = ins;
      c.st      = st;
      c.imemAck = 1'($urandom_range(0, 1));
      c.dmemAck = 1'($urandom_range(0, 1));
      c.brIn    = 1'($urandom_range(0, 1));
      return c;
   endfunction

   task automatic pushHalt(input logic [31:0] ins, input logic be, input logic ill);
      cycle_t c;
      for (int i = 0; i < 3; i++) begin
         c = idleCycle(ins, 3'(ST_HALT));
         c.busErr = be;
         c.illOp  = ill;
         plan.push_back(c);
      end
   endtask

   // Expected script: fd idle fetch cycles before imem_ack, md idle MEM cycles before dmem_ack;
   // a delay of TIMEOUT or more means the ack never comes.
   task automatic addInstr(input logic [31:0] ins, input logic br, input int fd, input int md);
      cycle_t c;
      int cls;
      logic [2:0] imm;
      cls = classOf(ins[6:0]);
      imm = immOf(cls);
      for (int i = 0; i < ((fd >= TIMEOUT) ? TIMEOUT : fd); i++) begin
         c = idleCycle(ins, 3'(ST_FETCH));
         c.imemReq = 1'b1;
         c.imemAck = 1'b0;
         plan.push_back(c);
      end
      if (fd >= TIMEOUT) begin
         pushHalt(ins, 1'b1, 1'b0);
         return;
      end
      c = idleCycle(ins, 3'(ST_FETCH));
      c.imemReq = 1'b1; c.imemAck = 1'b1; c.irWe = 1'b1;
      plan.push_back(c);
      c = idleCycle(ins, 3'(ST_DECODE));
      c.chkImm = (cls != 9); c.immSel = imm;
      plan.push_back(c);
`ifdef ILLEGAL_TRAP_EN
      if (cls == 9) begin
         pushHalt(ins, 1'b0, 1'b1);
         return;
      end
`endif
      c = idleCycle(ins, 3'(ST_EXEC));
      c.chkImm = (cls != 9); c.immSel = imm;
      c.chkAlt = 1'b1; c.altB = !(cls == 1 || cls == 4);
      if (cls == 4) begin
         c.brIn = br; c.pcWe = 1'b1; c.pcSel = br ? 2'd1 : 2'd0;
      end else if (cls == 9) begin
         c.pcWe = 1'b1; c.pcSel = 2'd0;
      end
      plan.push_back(c);
      if (cls == 4 || cls == 9) return;
      if (cls == 2 || cls == 3) begin
         for (int i = 0; i < ((md >= TIMEOUT) ? TIMEOUT : md + 1); i++) begin
            c = idleCycle(ins, 3'(ST_MEM));
            c.chkImm = 1'b1; c.immSel = imm;
            c.dmemReq = 1'b1; c.dmemWe = (cls == 3);
            c.dmemAck = (i == md);
            if (i == md && cls == 3) begin
               c.pcWe = 1'b1; c.pcSel = 2'd0;
            end
            plan.push_back(c);
         end
         if (md >= TIMEOUT) begin
            pushHalt(ins, 1'b1, 1'b0);
            return;
         end
         if (cls == 3) return;
      end
      c = idleCycle(ins, 3'(ST_WB));
      c.chkImm = 1'b1; c.immSel = imm;
      c.regWe = 1'b1; c.pcWe = 1'b1;
      c.wbSel = (cls == 2) ? 2'd1 : (cls == 5 || cls == 6) ? 2'd2 : 2'd0;
      c.pcSel = (cls == 5) ? 2'd1 : (cls == 6) ? 2'd2 : 2'd0;
      plan.push_back(c);
   endtask

   task automatic applyStimulus(input cycle_t c);
      inst           = c.ins;
      brTaken        = c.brIn;
      memIf.imem_ack = c.imemAck;
      memIf.dmem_ack = c.dmemAck;
   endtask

   task automatic checkCycle(input cycle_t c);
      checkOutput("state", 32'(stateOut), 32'(c.st));
      checkOutput("strobes{imem_req,ir_we,dmem_req,dmem_we,pc_we,reg_we}",
                  32'({memIf.imem_req, irWe, memIf.dmem_req, memIf.dmem_we, pcWe, regWe}),
                  32'({c.imemReq, c.irWe, c.dmemReq, c.dmemWe, c.pcWe, c.regWe}));
      if (c.pcWe)   checkOutput("pc_sel", 32'(pcSel), 32'(c.pcSel));
      if (c.regWe)  checkOutput("wb_sel", 32'(wbSel), 32'(c.wbSel));
      if (c.chkImm) checkOutput("ImmSel", 32'(immSel), 32'(c.immSel));
      if (c.chkAlt) checkOutput("alu_src_b", 32'(aluSrcB), 32'(c.altB));
      checkOutput("bus_err", 32'(busErr), 32'(c.busErr));
`ifdef ILLEGAL_TRAP_EN
      checkOutput("illegal_op", 32'(illegalOp), 32'(c.illOp));
`endif
   endtask

   // Called and returns at a falling edge; inputs for a cycle are applied there.
   task automatic runPlan();
      cycle_t c;
      while (plan.size() > 0) begin
         c = plan.pop_front();
         applyStimulus(c);
         #1;
         checkCycle(c);
         @(negedge clock);
      end
   endtask

   task automatic applyReset();
      reset          = 1'b1;
      memIf.imem_ack = 1'b0;
      memIf.dmem_ack = 1'b0;
      #1;
      checkOutput("reset state", 32'(stateOut), 32'(ST_FETCH));
      checkOutput("reset strobes",
                  32'({memIf.imem_req, irWe, memIf.dmem_req, memIf.dmem_we, pcWe, regWe}), 32'h0);
      checkOutput("reset bus_err", 32'(busErr), 32'h0);
      checkOutput("reset ImmSel", 32'(immSel), 32'(I_IMM));
`ifdef ILLEGAL_TRAP_EN
      checkOutput("reset illegal_op", 32'(illegalOp), 32'h0);
`endif
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [6:0]  opcTable [9];
      logic [6:0]  opc;
      logic [31:0] ins;
      int          pick;
      opcTable = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      memIf.imem_ack = 1'b0;
      memIf.dmem_ack = 1'b0;
      repeat (2) @(negedge clock);
      applyReset();

      addInstr(32'h00500093, 1'b0, 0, 0);
      addInstr(32'h00112223, 1'b0, 0, 3);
      addInstr(32'h00208463, 1'b1, 0, 0);
      addInstr(32'h00208463, 1'b0, 2, 0);
      addInstr(32'h00500093, 1'b0, TIMEOUT - 1, 0);
      addInstr(32'h0000A103, 1'b0, 0, TIMEOUT - 1);
      runPlan();

      addInstr(32'h0000007F, 1'b0, 0, 0);
      runPlan();
`ifdef ILLEGAL_TRAP_EN
      applyReset();
`endif

      // Load interrupted by reset after two MEM wait cycles
      addInstr(32'h0000A103, 1'b0, 0, 10);
      while (plan.size() > 5) void'(plan.pop_back());
      runPlan();
      applyReset();
      addInstr(32'h00500093, 1'b0, 1, 0);
      runPlan();

      addInstr(32'h00500093, 1'b0, TIMEOUT, 0);
      runPlan();
      applyReset();
      addInstr(32'h0000A103, 1'b0, 0, TIMEOUT);
      runPlan();
      applyReset();

      for (int n = 0; n < 150; n++) begin
         pick = $urandom_range(0, 10);
         if (pick < 9)
            opc = opcTable[pick];
         else if (pick == 9)
            opc = {5'($urandom), 2'($urandom_range(0, 2))};
         else
            opc = ($urandom_range(0, 1) == 1) ? 7'h73 : 7'h0F;
         ins = {25'($urandom), opc};
         addInstr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
         runPlan();
`ifdef ILLEGAL_TRAP_EN
         if (classOf(opc) == 9) applyReset();
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
